// File: rtl/piso_serializer.sv
// Parallel-in / serial-out transmitter: loads a DW-bit word on in_vld/in_rdy,
// then emits it one bit per enabled cycle. Optional parity bit: PISO_PARITY_EN.
module piso_serializer #(
    parameter int unsigned DW        = 16,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] inp,
    output logic          sout,
    output logic          sout_vld,
    output logic          done
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_DONE   = 2'd2,
        S_PARITY = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q,   cnt_d;
`ifdef PISO_PARITY_EN
    logic          parity_q, parity_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        if (enb) begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_vld) begin
                        shreg_d  = inp;
                        cnt_d    = '0;
`ifdef PISO_PARITY_EN
                        parity_d = ^inp;
`endif
                        state_d  = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg_d = MSB_FIRST ? {shreg_q[DW-2:0], 1'b0}
                                        : {1'b0, shreg_q[DW-1:1]};
                    // Counter parks on the last index instead of wrapping.
                    if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef PISO_PARITY_EN
                S_PARITY: state_d = S_DONE;
`endif
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // All outputs decode from registered state only, so enb=0 holds them.
    always_comb begin
        in_rdy   = 1'b0;
        sout     = 1'b0;
        sout_vld = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_IDLE:  in_rdy = 1'b1;
            S_SHIFT: begin
                sout_vld = 1'b1;
                sout     = MSB_FIRST ? shreg_q[DW-1] : shreg_q[0];
            end
`ifdef PISO_PARITY_EN
            S_PARITY: begin
                sout_vld = 1'b1;
                sout     = parity_q;
            end
`endif
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an LSB-first and an MSB-first instance
// share clock, reset, enable and data; expected bit streams are hand-written.
module tb_piso_serializer;

    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enb;
    logic          vld_l, vld_m;
    logic [DW-1:0] inp;
    logic          rdy_l, sout_l, svld_l, done_l;
    logic          rdy_m, sout_m, svld_m, done_m;

    logic          sel;
    logic          c_rdy, c_sout, c_svld, c_done;

    int unsigned   checks = 0;
    int unsigned   errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.DW(DW), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .enb(enb), .in_vld(vld_l), .in_rdy(rdy_l),
        .inp(inp), .sout(sout_l), .sout_vld(svld_l), .done(done_l)
    );

    piso_serializer #(.DW(DW), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .enb(enb), .in_vld(vld_m), .in_rdy(rdy_m),
        .inp(inp), .sout(sout_m), .sout_vld(svld_m), .done(done_m)
    );

    always_comb begin
        c_rdy  = sel ? rdy_m  : rdy_l;
        c_sout = sel ? sout_m : sout_l;
        c_svld = sel ? svld_m : svld_l;
        c_done = sel ? done_m : done_l;
    end

    typedef struct {
        logic          msb;
        logic [DW-1:0] word;
        logic [DW-1:0] seq;   // seq[i] = i-th emitted bit
        logic          par;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vld(input logic v);
        if (sel) vld_m = v;
        else     vld_l = v;
    endtask

    // Called in the first SHIFT cycle; returns in the following IDLE cycle.
    task automatic expect_stream(input string tag, input logic [DW-1:0] seq, input logic par);
        for (int i = 0; i < DW; i++) begin
            chk($sformatf("%s bit%0d {vld,sout}", tag, i), {30'd0, c_svld, c_sout}, {30'd0, 1'b1, seq[i]});
            step();
        end
`ifdef PISO_PARITY_EN
        chk($sformatf("%s parity {vld,sout}", tag), {30'd0, c_svld, c_sout}, {30'd0, 1'b1, par});
        step();
`else
        if (par === 1'bx) $display("note: unexpected unknown parity reference");
`endif
        chk($sformatf("%s done {done,vld,sout,rdy}", tag),
            {28'd0, c_done, c_svld, c_sout, c_rdy}, {28'd0, 4'b1000});
        step();
        chk($sformatf("%s idle {done,rdy}", tag), {30'd0, c_done, c_rdy}, {30'd0, 2'b01});
    endtask

    task automatic run_word(input string tag, input logic [DW-1:0] word,
                            input logic [DW-1:0] seq, input logic par);
        chk($sformatf("%s rdy before load", tag), {31'd0, c_rdy}, 32'd1);
        inp = word;
        set_vld(1'b1);
        step();
        set_vld(1'b0);
        expect_stream(tag, seq, par);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; enb = 1'b1; vld_l = 1'b0; vld_m = 1'b0; inp = '0; sel = 1'b0;

        tbl[0] = '{msb: 1'b0, word: 16'hA5C3, seq: 16'hA5C3, par: 1'b0};
        tbl[1] = '{msb: 1'b0, word: 16'h0001, seq: 16'h0001, par: 1'b1};
        tbl[2] = '{msb: 1'b1, word: 16'h8001, seq: 16'h8001, par: 1'b0};
        tbl[3] = '{msb: 1'b1, word: 16'h1234, seq: 16'h2C48, par: 1'b1};
        tbl[4] = '{msb: 1'b0, word: 16'hFFFF, seq: 16'hFFFF, par: 1'b0};
        tbl[5] = '{msb: 1'b0, word: 16'h5678, seq: 16'h5678, par: 1'b0};

        // Reset state, with in_vld asserted during reset on both instances.
        #2;
        vld_l = 1'b1; vld_m = 1'b1; inp = 16'hFFFF;
        step();
        step();
        chk("reset lsb {rdy,sout,vld,done}", {28'd0, rdy_l, sout_l, svld_l, done_l}, {28'd0, 4'b1000});
        chk("reset msb {rdy,sout,vld,done}", {28'd0, rdy_m, sout_m, svld_m, done_m}, {28'd0, 4'b1000});
        vld_l = 1'b0; vld_m = 1'b0;
        rst = 1'b0;
        step();
        chk("post-reset lsb rdy", {31'd0, rdy_l}, 32'd1);

        // enb=0 blocks a load even with in_vld high.
        enb = 1'b0; vld_l = 1'b1; inp = 16'h00FF;
        step();
        step();
        chk("enb0 no load {rdy,vld}", {30'd0, rdy_l, svld_l}, {30'd0, 2'b10});
        vld_l = 1'b0; enb = 1'b1;
        step();

        for (int k = 0; k < 6; k++) begin
            sel = tbl[k].msb;
            run_word($sformatf("vec%0d", k), tbl[k].word, tbl[k].seq, tbl[k].par);
            step();
        end

        // enb toggling during a word: each bit held for two cycles.
        sel = 1'b0;
        chk("T3 rdy before load", {31'd0, c_rdy}, 32'd1);
        inp = 16'hA5C3; vld_l = 1'b1;
        step();
        vld_l = 1'b0;
        for (int i = 0; i < DW; i++) begin
            chk($sformatf("T3 bit%0d a", i), {30'd0, c_svld, c_sout}, {30'd0, 1'b1, tbl[0].seq[i]});
            enb = 1'b0;
            step();
            chk($sformatf("T3 bit%0d b", i), {30'd0, c_svld, c_sout}, {30'd0, 1'b1, tbl[0].seq[i]});
            enb = 1'b1;
            step();
        end
`ifdef PISO_PARITY_EN
        enb = 1'b0;
        step();
        chk("T3 parity held", {30'd0, c_svld, c_sout}, {30'd0, 2'b10});
        enb = 1'b1;
        step();
`endif
        chk("T3 done a", {30'd0, c_done, c_svld}, {30'd0, 2'b10});
        enb = 1'b0;
        step();
        chk("T3 done held", {30'd0, c_done, c_rdy}, {30'd0, 2'b10});
        enb = 1'b1;
        step();
        chk("T3 idle {done,rdy}", {30'd0, c_done, c_rdy}, {30'd0, 2'b01});
        step();

        // Reset after the 5th bit aborts the word; in_vld during reset ignored.
        inp = 16'hFFFF; vld_l = 1'b1;
        step();
        vld_l = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("T4 bit%0d", i), {30'd0, c_svld, c_sout}, 32'd3);
            step();
        end
        #2 rst = 1'b1;
        #1;
        chk("T4 async reset {vld,rdy,done}", {29'd0, c_svld, c_rdy, c_done}, {29'd0, 3'b010});
        vld_l = 1'b1;
        step();
        chk("T4 in reset {vld,rdy}", {30'd0, c_svld, c_rdy}, {30'd0, 2'b01});
        rst = 1'b0;
        vld_l = 1'b0;
        step();
        chk("T4 after release vld", {31'd0, c_svld}, 32'd0);
        run_word("T4 zero", 16'h0000, 16'h0000, 1'b0);
        step();

        // in_vld held high: back-to-back words, busy-time inp changes ignored.
        inp = 16'h1234; vld_l = 1'b1;
        step();
        inp = 16'h5678;
        expect_stream("T5 w0", 16'h1234, 1'b1);
        step();
        vld_l = 1'b0;
        expect_stream("T5 w1", 16'h5678, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
